dac_voice_scheduler: RTL and testbench
======================================

DAC_VOICE_SCHEDULER -- requirements
Module: dac_voice_scheduler

Interface
REQ-001 Parameter NUM_VOICES, default 4, number of voice requesters sharing the DAC sample slot (power of two, 2..8).
REQ-002 Parameter SAMPLE_W, default 16, signed sample width.
REQ-003 i_clk  input  1  system clock, 50 MHz; all state in this domain.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_daclrck  input  1  codec LR clock, asynchronous to i_clk; low = left half, high = right half.
REQ-006 i_enable  input  1  scheduler run enable.
REQ-007 i_voice_en  input  NUM_VOICES  per-voice poll mask.
REQ-008 i_voice_valid  input  NUM_VOICES  per-voice sample valid.
REQ-009 i_voice_sample  input  NUM_VOICES x SAMPLE_W  signed per-voice sample.
REQ-010 o_voice_ready  output  NUM_VOICES  per-voice accept strobe.
REQ-011 o_sound  output  SAMPLE_W  signed mixed sample for the DAC serializer.
REQ-012 o_sound_upd  output  1  one-cycle pulse when o_sound changes.
REQ-013 o_underrun  output  NUM_VOICES  sticky per-voice missed-sample flags.
REQ-014 o_overrun  output  1  sticky flag: frame edge arrived while not in WAIT_FRAME.

Function
REQ-015 i_daclrck SHALL pass a 2-flop synchronizer; rise/fall SHALL be one-cycle pulses derived from the synchronized value (3-cycle edge latency).
REQ-016 FSM states: IDLE, WAIT_FRAME, COLLECT, MIX, HOLD.
REQ-017 IDLE -> WAIT_FRAME when i_enable=1; any state -> IDLE the cycle after i_enable=0, discarding partial accumulation.
REQ-018 WAIT_FRAME -> COLLECT on synchronized rise (start of right half); accumulator cleared, slot index k=0.
REQ-019 COLLECT SHALL spend exactly one cycle per voice k=0..NUM_VOICES-1 in order; o_voice_ready[k]=1 in slot k only if i_voice_en[k]=1; all other ready bits 0.
REQ-020 Handshake in slot k: valid&ready -> sample added to accumulator; en=1 and valid=0 -> adds 0, sets o_underrun[k]; en=0 -> adds 0, no flag.
REQ-021 Accumulator width SHALL be SAMPLE_W+$clog2(NUM_VOICES) signed; no intermediate overflow.
REQ-022 MIX (one cycle): reduce accumulator to SAMPLE_W per REQ-031/032 into pending register; -> HOLD.
REQ-023 HOLD: on synchronized fall (start of left half) o_sound <= pending, o_sound_upd=1 for that cycle, -> WAIT_FRAME.
REQ-024 Latency: pending ready NUM_VOICES+1 cycles after rise detection; o_sound updates exactly once per LR frame, stable for the whole left+right period.
REQ-025 Rise or fall detected in COLLECT or MIX, or rise in HOLD: set o_overrun, edge ignored, FSM continues.
REQ-026 While i_enable=0, o_sound SHALL be forced to 0 on the next synchronized fall (with o_sound_upd pulse); held at 0 afterwards.
REQ-027 Underrun/overrun flags SHALL clear only on reset or the cycle i_enable rises.

Reset
REQ-028 On i_rst_n=0, immediately: state IDLE, o_sound=0, o_sound_upd=0, o_voice_ready=0, o_underrun=0, o_overrun=0, accumulator/pending=0, synchronizer flops=0.
REQ-029 Reset mid-COLLECT SHALL drop all ready strobes the same instant; no partial sample is ever published.
REQ-030 After deassertion, first publish only after a full rise->fall sequence (no publish on a fall seen before the first rise).

Configuration
REQ-031 DAC_SCHED_ATTEN_EN defined: reduction = arithmetic right shift by $clog2(NUM_VOICES); never clips.
REQ-032 DAC_SCHED_ATTEN_EN undefined: reduction = saturation to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].

Structure
REQ-033 Package dac_sched_pkg SHALL hold: sched_state_e enum, sample_t typedef, SAMPLE_MAX/SAMPLE_MIN constants.
REQ-034 One sub-module sync_edge_det: 2-flop synchronizer plus rise/fall pulse outputs, reused for i_daclrck.

Verification
REQ-035 4 voices enabled, always valid, samples 1000,2000,-500,100 -> after rise/fall, o_sound=2600 (sat build) / 650 (atten build), one o_sound_upd pulse.
REQ-036 Samples 30000,30000,0,0 -> o_sound=32767 (sat) / 15000 (atten); -30000 x4 -> -32768 (sat) / -30000 (atten).
REQ-037 i_voice_en=4'b1011, voice 1 valid=0 -> voice 1 contributes 0, o_underrun=4'b0010; voice 2 never sees ready, flag stays 0.
REQ-038 Toggle i_daclrck rise then fall within 3 i_clk cycles -> o_overrun=1, no publish that frame, next clean frame publishes normally.
REQ-039 Assert i_rst_n=0 during COLLECT slot 2 -> o_voice_ready=0 immediately, o_sound=0; after release, first update only after rise then fall.
REQ-040 Drop i_enable mid-stream with o_sound=2600 -> FSM IDLE next cycle, o_sound=0 at next fall with single upd pulse.

Source files
------------

// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC voice scheduler.
// - sched_state_e : scheduler FSM states
// - sample_t      : signed sample at the default width
// - SAMPLE_MAX / SAMPLE_MIN : saturation limits for sample_t
package dac_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitFrame,
    StCollect,
    StMix,
    StHold
  } sched_state_e;

  localparam int unsigned SampleWDef = 16;

  typedef logic signed [SampleWDef-1:0] sample_t;

  localparam sample_t SAMPLE_MAX = {1'b0, {(SampleWDef - 1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(SampleWDef - 1){1'b0}}};

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with one-cycle rise/fall pulses derived from the
// synchronized level. An input transition shows up as a pulse after two
// clock edges and is acted on by downstream logic at the third.
// Ports:
//   i_clk    - destination clock
//   i_rst_n  - asynchronous active-low reset (all flops clear to 0)
//   async_i  - asynchronous level input
//   rise_o   - one-cycle pulse on synchronized 0->1
//   fall_o   - one-cycle pulse on synchronized 1->0
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/dac_voice_scheduler.sv
// Time-multiplexes NUM_VOICES sample requesters into one DAC sample per LR
// frame. On the right-half start (LRCK rise) each voice gets one poll slot,
// the samples are summed, reduced to SAMPLE_W and published on the next
// left-half start (LRCK fall).
// Build option: define DAC_SCHED_ATTEN_EN to reduce the sum by an arithmetic
// shift of $clog2(NUM_VOICES); otherwise the sum is saturated to SAMPLE_W.
// Ports:
//   i_clk, i_rst_n  - system clock, asynchronous active-low reset
//   i_daclrck       - codec LR clock (asynchronous)
//   i_enable        - run enable
//   i_voice_en      - per-voice poll mask
//   i_voice_valid   - per-voice sample valid
//   i_voice_sample  - per-voice signed sample
//   o_voice_ready   - per-voice accept strobe (one slot per frame)
//   o_sound         - mixed sample, o_sound_upd pulses when it is written
//   o_underrun      - sticky per-voice missed sample flags
//   o_overrun       - sticky flag for frame edges arriving out of sequence
module dac_voice_scheduler
  import dac_sched_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned SAMPLE_W   = SampleWDef
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_daclrck,
  input  logic                                 i_enable,
  input  logic [NUM_VOICES-1:0]                i_voice_en,
  input  logic [NUM_VOICES-1:0]                i_voice_valid,
  input  logic [NUM_VOICES-1:0][SAMPLE_W-1:0]  i_voice_sample,
  output logic [NUM_VOICES-1:0]                o_voice_ready,
  output logic signed [SAMPLE_W-1:0]           o_sound,
  output logic                                 o_sound_upd,
  output logic [NUM_VOICES-1:0]                o_underrun,
  output logic                                 o_overrun
);

  localparam int unsigned IdxW = $clog2(NUM_VOICES);
  localparam int unsigned AccW = SAMPLE_W + IdxW;
  localparam logic [IdxW-1:0] LastSlot = IdxW'(NUM_VOICES - 1);

  logic lr_rise, lr_fall;

  sync_edge_det u_lrck_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .async_i (i_daclrck),
    .rise_o  (lr_rise),
    .fall_o  (lr_fall)
  );

  sched_state_e                  state_q, state_d;
  logic [IdxW-1:0]               slot_q, slot_d;
  logic signed [AccW-1:0]        acc_q, acc_d;
  logic signed [SAMPLE_W-1:0]    pend_q, pend_d;
  logic signed [SAMPLE_W-1:0]    sound_q, sound_d;
  logic                          upd_q, upd_d;
  logic [NUM_VOICES-1:0]         under_q, under_d;
  logic                          over_q, over_d;
  logic                          enable_q;
  // Set when the scheduler is disabled; the next fall publishes silence once.
  logic                          force_zero_q, force_zero_d;

  logic en_rise, en_fall;
  assign en_rise = i_enable & ~enable_q;
  assign en_fall = ~i_enable & enable_q;

  // Current slot's contribution, sign-extended to accumulator width.
  logic signed [SAMPLE_W-1:0] cur_sample;
  logic signed [AccW-1:0]     add_val;
  logic                       slot_en, slot_valid;

  assign cur_sample = i_voice_sample[slot_q];
  assign slot_en    = i_voice_en[slot_q];
  assign slot_valid = i_voice_valid[slot_q];

  always_comb begin
    add_val = '0;
    if (slot_en && slot_valid) begin
      add_val = {{IdxW{cur_sample[SAMPLE_W-1]}}, cur_sample};
    end
  end

  // Reduction of the full-width sum to the DAC sample width.
  logic signed [SAMPLE_W-1:0] reduced;

`ifdef DAC_SCHED_ATTEN_EN
  assign reduced = SAMPLE_W'(acc_q >>> IdxW);
`else
  localparam logic [SAMPLE_W-1:0] SatMax = {1'b0, {(SAMPLE_W - 1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] SatMin = {1'b1, {(SAMPLE_W - 1){1'b0}}};

  // The sum fits SAMPLE_W only if all bits above the sample sign bit agree.
  logic acc_ovf;
  assign acc_ovf = ~(&acc_q[AccW-1:SAMPLE_W-1]) & (|acc_q[AccW-1:SAMPLE_W-1]);

  always_comb begin
    reduced = acc_q[SAMPLE_W-1:0];
    if (acc_ovf) begin
      reduced = acc_q[AccW-1] ? SatMin : SatMax;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    acc_d        = acc_q;
    pend_d       = pend_q;
    sound_d      = sound_q;
    upd_d        = 1'b0;
    under_d      = under_q;
    over_d       = over_q;
    force_zero_d = force_zero_q;

    if (en_rise) begin
      under_d      = '0;
      over_d       = 1'b0;
      force_zero_d = 1'b0;
    end

    if (!i_enable) begin
      state_d = StIdle;
      slot_d  = '0;
      acc_d   = '0;
      if (en_fall) begin
        force_zero_d = 1'b1;
      end
      if (force_zero_q && lr_fall) begin
        sound_d      = '0;
        upd_d        = 1'b1;
        force_zero_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle: state_d = StWaitFrame;
        StWaitFrame: begin
          // A fall here (e.g. first after reset) is not a frame boundary.
          if (lr_rise) begin
            state_d = StCollect;
            acc_d   = '0;
            slot_d  = '0;
          end
        end
        StCollect: begin
          if (lr_rise || lr_fall) begin
            over_d = 1'b1;
          end
          acc_d = acc_q + add_val;
          if (slot_en && !slot_valid) begin
            under_d[slot_q] = 1'b1;
          end
          if (slot_q == LastSlot) begin
            state_d = StMix;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
        StMix: begin
          if (lr_rise || lr_fall) begin
            over_d = 1'b1;
          end
          pend_d  = reduced;
          state_d = StHold;
        end
        StHold: begin
          if (lr_rise) begin
            over_d = 1'b1;
          end else if (lr_fall) begin
            sound_d = pend_q;
            upd_d   = 1'b1;
            state_d = StWaitFrame;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      slot_q       <= '0;
      acc_q        <= '0;
      pend_q       <= '0;
      sound_q      <= '0;
      upd_q        <= 1'b0;
      under_q      <= '0;
      over_q       <= 1'b0;
      enable_q     <= 1'b0;
      force_zero_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      acc_q        <= acc_d;
      pend_q       <= pend_d;
      sound_q      <= sound_d;
      upd_q        <= upd_d;
      under_q      <= under_d;
      over_q       <= over_d;
      enable_q     <= i_enable;
      force_zero_q <= force_zero_d;
    end
  end

  // Ready decodes straight from registered state so reset drops it at once.
  always_comb begin
    o_voice_ready = '0;
    if (state_q == StCollect) begin
      o_voice_ready[slot_q] = slot_en;
    end
  end

  assign o_sound     = sound_q;
  assign o_sound_upd = upd_q;
  assign o_underrun  = under_q;
  assign o_overrun   = over_q;

endmodule

// File: tb/tb_dac_voice_scheduler.sv
module tb_dac_voice_scheduler;
  import dac_sched_pkg::*;

`ifdef DAC_SCHED_ATTEN_EN
  localparam int ExpMix  = 650;
  localparam int ExpHi   = 15000;
  localparam int ExpLo   = -30000;
  localparam int ExpMask = 275;
`else
  localparam int ExpMix  = 2600;
  localparam int ExpHi   = int'(SAMPLE_MAX);
  localparam int ExpLo   = int'(SAMPLE_MIN);
  localparam int ExpMask = 1100;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 lrck;
  logic                 enable;
  logic [3:0]           v_en;
  logic [3:0]           v_valid;
  logic [3:0][15:0]     v_sample;
  logic [3:0]           v_ready;
  logic signed [15:0]   sound;
  logic                 sound_upd;
  logic [3:0]           underrun;
  logic                 overrun;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int rdy1_cnt = 0;
  int rdy2_cnt = 0;

  always #10 clk = ~clk;

  dac_voice_scheduler #(
    .NUM_VOICES (4),
    .SAMPLE_W   (16)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_daclrck      (lrck),
    .i_enable       (enable),
    .i_voice_en     (v_en),
    .i_voice_valid  (v_valid),
    .i_voice_sample (v_sample),
    .o_voice_ready  (v_ready),
    .o_sound        (sound),
    .o_sound_upd    (sound_upd),
    .o_underrun     (underrun),
    .o_overrun      (overrun)
  );

  always @(negedge clk) begin
    if (sound_upd)  upd_cnt++;
    if (v_ready[1]) rdy1_cnt++;
    if (v_ready[2]) rdy2_cnt++;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_samples(input int s0, input int s1, input int s2, input int s3);
    v_sample[0] = 16'(s0);
    v_sample[1] = 16'(s1);
    v_sample[2] = 16'(s2);
    v_sample[3] = 16'(s3);
  endtask

  // One full LR frame: right half then left half; publish lands in the left half.
  task automatic run_frame();
    lrck = 1'b1;
    repeat (12) @(negedge clk);
    lrck = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int  u0;
    int  r1;
    int  r2;
    bit  found;

    rst_n   = 1'b0;
    lrck    = 1'b0;
    enable  = 1'b0;
    v_en    = 4'hF;
    v_valid = 4'hF;
    set_samples(1000, 2000, -500, 100);
    repeat (3) @(negedge clk);

    check_eq("rst_sound", int'(sound), 0);
    check_eq("rst_upd", int'(sound_upd), 0);
    check_eq("rst_ready", int'(v_ready), 0);
    check_eq("rst_underrun", int'(underrun), 0);
    check_eq("rst_overrun", int'(overrun), 0);

    // A fall seen before any rise must not publish.
    rst_n = 1'b1;
    lrck  = 1'b1;
    repeat (6) @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    u0   = upd_cnt;
    lrck = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("early_fall_upd", upd_cnt - u0, 0);
    check_eq("early_fall_sound", int'(sound), 0);

    // Basic mix.
    u0 = upd_cnt;
    run_frame();
    check_eq("mix_sound", int'(sound), ExpMix);
    check_eq("mix_upd", upd_cnt - u0, 1);
    u0 = upd_cnt;
    repeat (20) @(negedge clk);
    check_eq("mix_stable_upd", upd_cnt - u0, 0);
    check_eq("mix_stable_sound", int'(sound), ExpMix);

    // Positive and negative extremes.
    set_samples(30000, 30000, 0, 0);
    run_frame();
    check_eq("hi_sound", int'(sound), ExpHi);
    set_samples(-30000, -30000, -30000, -30000);
    u0 = upd_cnt;
    run_frame();
    check_eq("lo_sound", int'(sound), ExpLo);
    check_eq("lo_upd", upd_cnt - u0, 1);
    check_eq("clean_overrun", int'(overrun), 0);
    check_eq("clean_underrun", int'(underrun), 0);

    // Masked voice 2, voice 1 missing its sample.
    set_samples(1000, 2000, -500, 100);
    v_en    = 4'b1011;
    v_valid = 4'b1101;
    r1 = rdy1_cnt;
    r2 = rdy2_cnt;
    run_frame();
    check_eq("mask_sound", int'(sound), ExpMask);
    check_eq("mask_underrun", int'(underrun), 4'b0010);
    check_eq("mask_rdy2", rdy2_cnt - r2, 0);
    check_eq("mask_rdy1", rdy1_cnt - r1, 1);

    // Rise then fall inside three cycles: overrun, no publish this frame.
    v_en    = 4'hF;
    v_valid = 4'hF;
    u0   = upd_cnt;
    lrck = 1'b1;
    repeat (2) @(negedge clk);
    lrck = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("glitch_overrun", int'(overrun), 1);
    check_eq("glitch_upd", upd_cnt - u0, 0);
    check_eq("glitch_sound", int'(sound), ExpMask);
    u0 = upd_cnt;
    run_frame();
    check_eq("post_glitch_sound", int'(sound), ExpMix);
    check_eq("post_glitch_upd", upd_cnt - u0, 1);

    // Disable mid-stream: silence at the next fall with one pulse, then held.
    lrck = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b0;
    u0     = upd_cnt;
    repeat (2) @(negedge clk);
    check_eq("dis_ready", int'(v_ready), 0);
    check_eq("dis_hold_sound", int'(sound), ExpMix);
    lrck = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("dis_sound", int'(sound), 0);
    check_eq("dis_upd", upd_cnt - u0, 1);
    u0 = upd_cnt;
    run_frame();
    check_eq("dis_held_upd", upd_cnt - u0, 0);
    check_eq("dis_held_sound", int'(sound), 0);
    check_eq("dis_sticky_overrun", int'(overrun), 1);
    check_eq("dis_sticky_underrun", int'(underrun), 4'b0010);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("en_clr_overrun", int'(overrun), 0);
    check_eq("en_clr_underrun", int'(underrun), 0);

    // Reset in the middle of slot 2.
    run_frame();
    check_eq("pre_rst_sound", int'(sound), ExpMix);
    lrck  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (v_ready[2]) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("slot2_reached", int'(found), 1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_ready", int'(v_ready), 0);
    check_eq("midrst_sound", int'(sound), 0);
    check_eq("midrst_upd", int'(sound_upd), 0);
    lrck = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    u0    = upd_cnt;
    repeat (10) @(negedge clk);
    check_eq("post_rst_no_upd", upd_cnt - u0, 0);
    check_eq("post_rst_sound", int'(sound), 0);
    run_frame();
    check_eq("post_rst_frame_sound", int'(sound), ExpMix);
    check_eq("post_rst_frame_upd", upd_cnt - u0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
